decode_ctrl2: RTL and testbench

DECODE_CTRL2 -- requirements
Module: decode_ctrl2

---
 rtl/decode_ctrl2.sv | 78 +++++++
 tb/tb_decode_ctrl2.sv | 92 +++++++++
 2 files changed

// File: rtl/decode_ctrl2.sv
// ALU control bit 2 decoder: selects between decoder, address, MOV and INC/DEC sources, one registered cycle.
// Optional address-mode decode enabled by macro DECODE_CTRL2_ADDR_MODE_EN; no backpressure, outputs update every cycle.
module decode_ctrl2 #(
   parameter logic OUT_RST_VAL = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       Ctrl2,
   input  logic       INTERNAL_MOV,
   input  logic       ADDRESS_MODE,
   input  logic       INTERNAL_INC_DEC,
   input  logic       INTERNAL_DEC,
   output logic       Ctrl2_out,
   output logic [1:0] mode,
   output logic       err
);

   localparam logic [1:0] MODE_NORMAL = 2'b00;
   localparam logic [1:0] MODE_ADDR   = 2'b01;
   localparam logic [1:0] MODE_MOV    = 2'b10;
   localparam logic [1:0] MODE_INCDEC = 2'b11;

   logic       w_incdec_sel;
   logic       w_mov_sel;
   logic       w_addr_sel;
   logic       w_ctrl2_nxt;
   logic [1:0] w_mode_nxt;
   logic       w_err_nxt;

   logic       r_ctrl2_out;
   logic [1:0] r_mode;
   logic       r_err;

   assign w_incdec_sel = ~INTERNAL_INC_DEC;
   assign w_mov_sel    = ~INTERNAL_MOV;

`ifdef DECODE_CTRL2_ADDR_MODE_EN
   assign w_addr_sel = ~ADDRESS_MODE;
`else
   // Address requests fall through to the normal decode when the feature is off.
   assign w_addr_sel = 1'b0 & ~ADDRESS_MODE;
`endif

   // A decrement request without an active INC/DEC sequence is flagged but not decoded.
   assign w_err_nxt = INTERNAL_INC_DEC & ~INTERNAL_DEC;

   always_comb begin
      w_ctrl2_nxt = Ctrl2;
      w_mode_nxt  = MODE_NORMAL;
      if (w_incdec_sel) begin
         w_ctrl2_nxt = ~INTERNAL_DEC;
         w_mode_nxt  = MODE_INCDEC;
      end else if (w_mov_sel) begin
         w_ctrl2_nxt = 1'b0;
         w_mode_nxt  = MODE_MOV;
      end else if (w_addr_sel) begin
         w_ctrl2_nxt = 1'b0;
         w_mode_nxt  = MODE_ADDR;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ctrl2_out <= OUT_RST_VAL;
         r_mode      <= MODE_NORMAL;
         r_err       <= 1'b0;
      end else begin
         r_ctrl2_out <= w_ctrl2_nxt;
         r_mode      <= w_mode_nxt;
         r_err       <= w_err_nxt;
      end
   end

   assign Ctrl2_out = r_ctrl2_out;
   assign mode      = r_mode;
   assign err       = r_err;

endmodule

// File: tb/tb_decode_ctrl2.sv
// Directed bench for decode_ctrl2; expectations follow DECODE_CTRL2_ADDR_MODE_EN when defined.
module tb_decode_ctrl2;

   logic       clk = 1'b0;
   logic       rst;
   logic       Ctrl2;
   logic       INTERNAL_MOV;
   logic       ADDRESS_MODE;
   logic       INTERNAL_INC_DEC;
   logic       INTERNAL_DEC;
   logic       Ctrl2_out;
   logic [1:0] mode;
   logic       err;

   int n_checks = 0;
   int n_errors = 0;

`ifdef DECODE_CTRL2_ADDR_MODE_EN
   localparam logic       ADDR_OUT  = 1'b0;
   localparam logic [1:0] ADDR_MODE = 2'b01;
`else
   localparam logic       ADDR_OUT  = 1'b1;
   localparam logic [1:0] ADDR_MODE = 2'b00;
`endif

   decode_ctrl2 #(.OUT_RST_VAL(1'b1)) dut (
      .clk              (clk),
      .rst              (rst),
      .Ctrl2            (Ctrl2),
      .INTERNAL_MOV     (INTERNAL_MOV),
      .ADDRESS_MODE     (ADDRESS_MODE),
      .INTERNAL_INC_DEC (INTERNAL_INC_DEC),
      .INTERNAL_DEC     (INTERNAL_DEC),
      .Ctrl2_out        (Ctrl2_out),
      .mode             (mode),
      .err              (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0b, expected %0b", tag, obs, exp);
      end
   endtask

   // Drive one input vector, clock it in, then compare all three outputs.
   task automatic step(input string tag, input logic r, input logic c2, input logic mov,
                       input logic addr, input logic incdec, input logic dec,
                       input logic e_out, input logic [1:0] e_mode, input logic e_err);
      rst              = r;
      Ctrl2            = c2;
      INTERNAL_MOV     = mov;
      ADDRESS_MODE     = addr;
      INTERNAL_INC_DEC = incdec;
      INTERNAL_DEC     = dec;
      @(posedge clk);
      #1;
      chk({tag, ".out"},  {1'b0, Ctrl2_out}, {1'b0, e_out});
      chk({tag, ".mode"}, mode,              e_mode);
      chk({tag, ".err"},  {1'b0, err},       {1'b0, e_err});
   endtask

   initial begin
      //    tag          rst c2 mov adr inc dec  out mode   err
      step("reset",      1, 0, 0,  0,  0,  0,   1, 2'b00, 0);
      step("norm0",      0, 0, 1,  1,  1,  1,   0, 2'b00, 0);
      step("norm1",      0, 1, 1,  1,  1,  1,   1, 2'b00, 0);
      step("mov_a1",     0, 1, 0,  1,  1,  1,   0, 2'b10, 0);
      step("mov_a0",     0, 1, 0,  0,  1,  1,   0, 2'b10, 0);
      step("inc",        0, 1, 0,  1,  0,  1,   0, 2'b11, 0);
      step("dec",        0, 1, 0,  1,  0,  0,   1, 2'b11, 0);
      step("inc_a0",     0, 1, 0,  0,  0,  1,   0, 2'b11, 0);
      step("dec_a0",     0, 0, 1,  0,  0,  0,   1, 2'b11, 0);
      step("addr",       0, 1, 1,  0,  1,  1,   ADDR_OUT, ADDR_MODE, 0);
      step("ill_norm1",  0, 1, 1,  1,  1,  0,   1, 2'b00, 1);
      step("ill_norm0",  0, 0, 1,  1,  1,  0,   0, 2'b00, 1);
      step("ill_mov",    0, 1, 0,  1,  1,  0,   0, 2'b10, 1);
      step("ill_clear",  0, 1, 1,  1,  1,  1,   1, 2'b00, 0);
      step("pre_rst",    0, 0, 1,  1,  1,  0,   0, 2'b00, 1);
      step("mid_rst",    1, 1, 0,  1,  0,  0,   1, 2'b00, 0);
      step("mid_rst2",   1, 0, 0,  1,  0,  1,   1, 2'b00, 0);
      step("post_rst",   0, 0, 0,  1,  0,  1,   0, 2'b11, 0);
      step("post_dec",   0, 1, 1,  1,  0,  0,   1, 2'b11, 0);
      step("back_norm",  0, 0, 1,  1,  1,  1,   0, 2'b00, 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
